// File: rtl/onehot_entry_pkg.sv
// Shared types and constants for the one-hot digit entry block.
// Segment patterns are active-low, ordered gfedcba.
package onehot_entry_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned SEG_W  = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        HELD   = 2'd2,
        ERR    = 2'd3
    } entry_state_t;

    localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Lowest set bit wins; an all-zero pattern encodes as 0.
    function automatic logic [CODE_W-1:0] lowest_index(input logic [15:0] pat);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (pat[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

    function automatic logic is_multi(input logic [15:0] pat);
        return (pat & (pat - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational 4-bit code to active-low 7-segment lookup with blanking.
module seg7_digit
    import onehot_entry_pkg::*;
(
    input  logic [CODE_W-1:0] value,
    input  logic              blank,
    output logic [SEG_W-1:0]  seg_c
);

    always_comb begin
        seg_c = blank ? SEG_BLANK : SEG_LUT[value];
    end

endmodule

// File: rtl/onehot_digit_entry.sv
// Debounced one-hot switch entry: commits one digit per press into a shift
// register and drives HEX. Define ONEHOT_ENTRY_BLANK_EMPTY_EN to blank empty digits.
module onehot_digit_entry
    import onehot_entry_pkg::*;
#(
    parameter int unsigned N_IN            = 10,
    parameter int unsigned N_DIGITS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic [N_IN-1:0]              SW,
    input  logic                         clear,
    output logic [CODE_W-1:0]            code,
    output logic                         code_valid,
    output logic                         multi_err,
    output logic [CODE_W*N_DIGITS-1:0]   digits,
    output logic [SEG_W*N_DIGITS-1:0]    HEX
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef ONEHOT_ENTRY_BLANK_EMPTY_EN
    localparam logic [SEG_W-1:0] EMPTY_SEG = SEG_BLANK;
`else
    localparam logic [SEG_W-1:0] EMPTY_SEG = SEG_LUT[0];
`endif

    logic [N_IN-1:0]   sw_meta;
    logic [N_IN-1:0]   sw_sync;
    logic [N_IN-1:0]   sw_prev;
    logic [CNT_W-1:0]  cnt;

    entry_state_t      state;
    entry_state_t      state_nx;
    logic              commit_c;

    logic [15:0]       pat_c;
    logic              stable_c;
    logic              pat_zero_c;
    logic              pat_multi_c;
    logic [CODE_W-1:0] idx_c;

    logic [CODE_W-1:0] dig_q  [N_DIGITS];
    logic [CODE_W-1:0] dig_nx [N_DIGITS];
    logic [N_DIGITS-1:0]       blank_c;
    logic [SEG_W*N_DIGITS-1:0] hex_c;

    // Two-flop synchronizer followed by a saturating stability counter.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
            sw_prev <= '0;
            cnt     <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
            if (sw_sync != sw_prev) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pat_c       = 16'(sw_prev);
        stable_c    = (cnt == CNT_MAX);
        pat_zero_c  = (pat_c == 16'd0);
        pat_multi_c = is_multi(pat_c);
        idx_c       = lowest_index(pat_c);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A new digit is accepted only from IDLE; HELD waits for a full release.
    always_comb begin
        state_nx = state;
        commit_c = 1'b0;
        case (state)
            IDLE: begin
                if (stable_c && pat_multi_c) begin
                    state_nx = ERR;
                end else if (stable_c && !pat_zero_c) begin
                    state_nx = COMMIT;
                    commit_c = 1'b1;
                end
            end
            COMMIT: state_nx = HELD;
            HELD: begin
                if (stable_c && pat_zero_c) begin
                    state_nx = IDLE;
                end else if (stable_c && pat_multi_c) begin
                    state_nx = ERR;
                end
            end
            ERR: begin
                if (stable_c && pat_zero_c) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Clear applies before the shift, so a coincident commit lands in an empty register.
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            dig_nx[i] = clear ? '0 : dig_q[i];
        end
        if (commit_c) begin
            for (int i = N_DIGITS - 1; i > 0; i--) begin
                dig_nx[i] = clear ? '0 : dig_q[i-1];
            end
            dig_nx[0] = idx_c;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            code       <= '0;
            code_valid <= 1'b0;
            multi_err  <= 1'b0;
            dig_q      <= '{default: '0};
            HEX        <= {N_DIGITS{EMPTY_SEG}};
        end else begin
            code_valid <= commit_c;
            multi_err  <= (state_nx == ERR);
            if (commit_c) code <= idx_c;
            dig_q      <= dig_nx;
            HEX        <= hex_c;
        end
    end

`ifdef ONEHOT_ENTRY_BLANK_EMPTY_EN
    logic [N_DIGITS-1:0] loaded_q;
    logic [N_DIGITS-1:0] loaded_nx;

    // Loaded flags track which digits hold a committed value.
    always_comb begin
        loaded_nx = clear ? '0 : loaded_q;
        if (commit_c) begin
            for (int i = N_DIGITS - 1; i > 0; i--) begin
                loaded_nx[i] = clear ? 1'b0 : loaded_q[i-1];
            end
            loaded_nx[0] = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            loaded_q <= '0;
        end else begin
            loaded_q <= loaded_nx;
        end
    end

    always_comb begin
        blank_c = ~loaded_q;
    end
`else
    always_comb begin
        blank_c = '0;
    end
`endif

    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            digits[i*CODE_W +: CODE_W] = dig_q[i];
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_seg
        seg7_digit u_seg (
            .value (dig_q[g]),
            .blank (blank_c[g]),
            .seg_c (hex_c[g*SEG_W +: SEG_W])
        );
    end

endmodule

// File: tb/tb_onehot_digit_entry.sv
// Directed self-checking bench for onehot_digit_entry (DEBOUNCE_CYCLES=4).
module tb_onehot_digit_entry;

    logic        CLOCK_50;
    logic        reset;
    logic [9:0]  SW;
    logic        clear;
    logic [3:0]  code;
    logic        code_valid;
    logic        multi_err;
    logic [15:0] digits;
    logic [27:0] HEX;

    int vectors;
    int miscompares;
    int pulses;

`ifdef ONEHOT_ENTRY_BLANK_EMPTY_EN
    localparam logic [6:0] E = 7'b1111111;
`else
    localparam logic [6:0] E = 7'b1000000;
`endif

    onehot_digit_entry #(
        .N_IN            (10),
        .N_DIGITS        (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .SW         (SW),
        .clear      (clear),
        .code       (code),
        .code_valid (code_valid),
        .multi_err  (multi_err),
        .digits     (digits),
        .HEX        (HEX)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (code_valid === 1'b1) pulses++;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int k);
        SW = 10'(1) << k;
        tick(10);
        SW = '0;
        tick(10);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pulses      = 0;
        reset = 1'b1;
        SW    = '0;
        clear = 1'b0;

        // 1: reset
        tick(3);
        reset = 1'b0;
        pulses = 0;
        tick(2);
        check("rst_digits", 64'(digits), 64'h0);
        check("rst_code", 64'(code), 64'h0);
        check("rst_multi", 64'(multi_err), 64'h0);
        check("rst_hex", 64'(HEX), 64'({E, E, E, E}));
        tick(5);
        check("rst_pulses", 64'(pulses), 64'd0);

        // 2: single press of bit 3
        SW = 10'b0000001000;
        tick(10);
        check("p3_pulses", 64'(pulses), 64'd1);
        check("p3_code", 64'(code), 64'd3);
        check("p3_digits", 64'(digits), 64'h0003);
        check("p3_hex", 64'(HEX), 64'({E, E, E, 7'b0110000}));
        SW = '0;
        tick(10);
        check("p3_release", 64'(pulses), 64'd1);

        // 3: sequence 1..5
        for (int k = 1; k <= 5; k++) press(k);
        check("seq_pulses", 64'(pulses), 64'd6);
        check("seq_digits", 64'(digits), 64'h2345);
        check("seq_hex", 64'(HEX), 64'({7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}));

        // 4: bounce on bit 7
        for (int i = 0; i < 10; i++) begin
            SW = (i % 2 == 0) ? 10'b0010000000 : 10'b0;
            tick(2);
        end
        SW = '0;
        tick(10);
        check("bnc_pulses", 64'(pulses), 64'd6);
        check("bnc_digits", 64'(digits), 64'h2345);

        // 5: multi-hot bits 2 and 6
        SW = 10'b0001000100;
        tick(10);
        check("mh_err", 64'(multi_err), 64'd1);
        check("mh_pulses", 64'(pulses), 64'd6);
        check("mh_code", 64'(code), 64'd5);
        check("mh_digits", 64'(digits), 64'h2345);
        SW = '0;
        tick(10);
        check("mh_clr", 64'(multi_err), 64'd0);
        press(6);
        check("mh_p6_pulses", 64'(pulses), 64'd7);
        check("mh_p6_code", 64'(code), 64'd6);
        check("mh_p6_digits", 64'(digits), 64'h3456);

        // 6: long hold, clear while held
        SW = 10'b1000000000;
        tick(100);
        check("hold_pulses", 64'(pulses), 64'd8);
        check("hold_digits", 64'(digits), 64'h4569);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_digits", 64'(digits), 64'h0);
        check("clr_code", 64'(code), 64'd9);
        tick(20);
        check("clr_pulses", 64'(pulses), 64'd8);
        check("clr_hex", 64'(HEX), 64'({E, E, E, E}));
        SW = '0;
        tick(10);

        // clear coincident with a commit
        press(1);
        check("pre_co_digits", 64'(digits), 64'h0001);
        SW = 10'b0000010000;
        tick(6);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("co_valid", 64'(code_valid), 64'd1);
        check("co_digits", 64'(digits), 64'h0004);
        check("co_pulses", 64'(pulses), 64'd10);
        tick(1);
        check("co_hex", 64'(HEX), 64'({E, E, E, 7'b0011001}));
        SW = '0;
        tick(10);

        // reset while held, then recommit of the still-held switch
        SW = 10'b0100000000;
        tick(10);
        check("rh_digits", 64'(digits), 64'h0048);
        reset = 1'b1;
        tick(2);
        check("rh_rst_digits", 64'(digits), 64'h0);
        reset = 1'b0;
        tick(10);
        check("rh_pulses", 64'(pulses), 64'd12);
        check("rh_code", 64'(code), 64'd8);
        check("rh_after", 64'(digits), 64'h0008);
        SW = '0;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
